// File: rtl/data_mem_access_ctrl.sv
// Memory-stage load/store controller: drives a multi-cycle word memory, stalls the
// pipeline with BUSYWAIT, and returns lane-selected, sign/zero-extended load data.
module data_mem_access_ctrl (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [3:0]  READ_WRITE,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] WRITE_DATA,
  output logic [31:0] READ_DATA,
  output logic        BUSYWAIT,
  output logic        MISALIGNED,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [29:0] MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  output logic [3:0]  MEM_BYTE_EN,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT
);

  localparam logic [3:0] RW_LB  = 4'b1000;
  localparam logic [3:0] RW_LH  = 4'b1001;
  localparam logic [3:0] RW_LW  = 4'b1010;
  localparam logic [3:0] RW_LBU = 4'b1100;
  localparam logic [3:0] RW_LHU = 4'b1101;
  localparam logic [3:0] RW_SB  = 4'b0001;
  localparam logic [3:0] RW_SH  = 4'b0010;
  localparam logic [3:0] RW_SW  = 4'b0011;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t      r_state;
  logic [3:0]  r_rw;
  logic [1:0]  r_off;

  logic        w_is_load;
  logic        w_is_store;
  logic        w_misal;
  logic        w_valid;
  logic [31:0] w_st_data;
  logic [3:0]  w_st_be;

  function automatic logic [31:0] fmt_load(input logic [3:0] rw, input logic [1:0] off,
                                           input logic [31:0] word);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {off, 3'b000};
    case (rw)
      RW_LB:   res = {{24{sh[7]}}, sh[7:0]};
      RW_LBU:  res = {24'd0, sh[7:0]};
      RW_LH:   res = {{16{sh[15]}}, sh[15:0]};
      RW_LHU:  res = {16'd0, sh[15:0]};
      default: res = word;
    endcase
    return res;
  endfunction

  always_comb begin
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    w_misal    = 1'b0;
    w_st_data  = WRITE_DATA;
    w_st_be    = 4'b0000;
    case (READ_WRITE)
      RW_LB, RW_LBU: w_is_load = 1'b1;
      RW_LH, RW_LHU: begin
        w_is_load = 1'b1;
        w_misal   = ADDRESS[0];
      end
      RW_LW: begin
        w_is_load = 1'b1;
        w_misal   = (ADDRESS[1:0] != 2'b00);
      end
      RW_SB: begin
        w_is_store = 1'b1;
        w_st_data  = {4{WRITE_DATA[7:0]}};
        w_st_be    = 4'b0001 << ADDRESS[1:0];
      end
      RW_SH: begin
        w_is_store = 1'b1;
        w_misal    = ADDRESS[0];
        w_st_data  = {2{WRITE_DATA[15:0]}};
        w_st_be    = 4'b0011 << ADDRESS[1:0];
      end
      RW_SW: begin
        w_is_store = 1'b1;
        w_misal    = (ADDRESS[1:0] != 2'b00);
        w_st_be    = 4'b1111;
      end
      default: ;
    endcase
    w_valid = (w_is_load || w_is_store) && !w_misal;
  end

  // Stall covers the request cycle in IDLE and every ACCESS cycle; DONE releases it.
  assign BUSYWAIT   = RESET && (((r_state == S_IDLE) && w_valid) || (r_state == S_ACCESS));
  assign MISALIGNED = RESET && (r_state == S_IDLE) && w_misal;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state       <= S_IDLE;
      r_rw          <= 4'b0000;
      r_off         <= 2'b00;
      READ_DATA     <= 32'd0;
      MEM_READ      <= 1'b0;
      MEM_WRITE     <= 1'b0;
      MEM_ADDRESS   <= 30'd0;
      MEM_WRITEDATA <= 32'd0;
      MEM_BYTE_EN   <= 4'b0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_valid) begin
            MEM_ADDRESS   <= ADDRESS[31:2];
            MEM_WRITEDATA <= w_st_data;
            MEM_BYTE_EN   <= w_st_be;
            r_rw          <= READ_WRITE;
            r_off         <= ADDRESS[1:0];
            MEM_READ      <= w_is_load;
            MEM_WRITE     <= w_is_store;
            r_state       <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (!MEM_BUSYWAIT) begin
            MEM_READ  <= 1'b0;
            MEM_WRITE <= 1'b0;
            if (MEM_READ) READ_DATA <= fmt_load(r_rw, r_off, MEM_READDATA);
            r_state   <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_access_ctrl.sv
// Bench for data_mem_access_ctrl: a small word memory with programmable wait states and
// a queue of expected access results popped as each access reaches its DONE cycle.
module tb_data_mem_access_ctrl;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [3:0]  READ_WRITE = 4'b0000;
  logic [31:0] ADDRESS = 32'd0;
  logic [31:0] WRITE_DATA = 32'd0;
  logic [31:0] READ_DATA;
  logic        BUSYWAIT;
  logic        MISALIGNED;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [29:0] MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [3:0]  MEM_BYTE_EN;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;

  data_mem_access_ctrl dut (
    .CLK(CLK), .RESET(RESET), .READ_WRITE(READ_WRITE), .ADDRESS(ADDRESS),
    .WRITE_DATA(WRITE_DATA), .READ_DATA(READ_DATA), .BUSYWAIT(BUSYWAIT),
    .MISALIGNED(MISALIGNED), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_BYTE_EN(MEM_BYTE_EN),
    .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  int          n_chk = 0;
  int          n_fail = 0;
  int          wait_k = 1;
  int          mem_cnt = 0;
  int          pipe_q = 0;
  logic        rd_ovr_en = 1'b0;
  logic [31:0] rd_ovr = 32'd0;
  logic [31:0] mem [0:15];

  // Memory model: access completes on its wait_k-th strobe cycle.
  assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (mem_cnt < wait_k - 1);
  assign MEM_READDATA = rd_ovr_en ? rd_ovr : mem[MEM_ADDRESS[3:0]];

  always @(posedge CLK) begin
    if (!RESET) begin
      mem_cnt <= 0;
      for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
    end else begin
      mem_cnt <= (MEM_READ || MEM_WRITE) ? mem_cnt + 1 : 0;
      if (MEM_WRITE && !MEM_BUSYWAIT)
        for (int i = 0; i < 4; i++)
          if (MEM_BYTE_EN[i]) mem[MEM_ADDRESS[3:0]][8*i +: 8] <= MEM_WRITEDATA[8*i +: 8];
    end
  end

  // Stand-in pipeline register: advances only when not stalled.
  always @(posedge CLK) if (!BUSYWAIT) pipe_q <= pipe_q + 1;

  typedef struct {
    int          busy;
    logic [29:0] maddr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        ld;
    logic        st;
    logic [31:0] rdata;
  } exp_t;
  exp_t exp_q[$];

  task automatic run_access(input logic [3:0] rw, input logic [31:0] addr, input logic [31:0] wd,
                            output int busy, output logic [29:0] maddr, output logic [3:0] be,
                            output logic [31:0] mwd, output logic ld, output logic st,
                            output logic stable, output logic off_done, output logic hold,
                            output logic [31:0] rdata);
    int p0;
    @(negedge CLK);
    READ_WRITE = rw; ADDRESS = addr; WRITE_DATA = wd;
    #1;
    busy = 0; stable = 1'b1; maddr = '0; be = '0; mwd = '0; ld = 1'b0; st = 1'b0;
    p0 = pipe_q;
    for (int c = 0; c < 60; c++) begin
      if (!BUSYWAIT) break;
      busy++;
      if (busy == 2) begin
        maddr = MEM_ADDRESS; be = MEM_BYTE_EN; mwd = MEM_WRITEDATA; ld = MEM_READ; st = MEM_WRITE;
      end else if (busy > 2) begin
        if (maddr !== MEM_ADDRESS || be !== MEM_BYTE_EN || mwd !== MEM_WRITEDATA ||
            ld !== MEM_READ || st !== MEM_WRITE) stable = 1'b0;
      end
      @(negedge CLK); #1;
    end
    if (BUSYWAIT) busy = -1;
    off_done = !MEM_READ && !MEM_WRITE;
    hold = (pipe_q == p0);
    rdata = READ_DATA;
  endtask

  task automatic go_idle();
    @(negedge CLK);
    READ_WRITE = 4'b0000;
  endtask

  int          o_busy;
  logic [29:0] o_maddr;
  logic [3:0]  o_be;
  logic [31:0] o_wd;
  logic [31:0] o_rdata;
  logic        o_ld, o_st, o_stable, o_off, o_hold;
  exp_t        e;

  task automatic test_reset_init();
    RESET = 1'b0; READ_WRITE = 4'b1010; ADDRESS = 32'h0000_0104;
    repeat (2) @(negedge CLK);
    #1;
    n_chk++; if (BUSYWAIT !== 1'b0) begin n_fail++; $display("FAIL rst_busywait: got %b want 0", BUSYWAIT); end
    n_chk++; if (READ_DATA !== 32'd0) begin n_fail++; $display("FAIL rst_read_data: got %h want 0", READ_DATA); end
    n_chk++; if ({MEM_READ, MEM_WRITE, MEM_BYTE_EN} !== 6'd0 || MEM_ADDRESS !== 30'd0 || MEM_WRITEDATA !== 32'd0) begin
      n_fail++; $display("FAIL rst_mem_outputs: got rd=%b wr=%b be=%b a=%h wd=%h want all 0",
                         MEM_READ, MEM_WRITE, MEM_BYTE_EN, MEM_ADDRESS, MEM_WRITEDATA);
    end
    READ_WRITE = 4'b0000;
    @(negedge CLK); RESET = 1'b1;
  endtask

  task automatic test_lw();
    wait_k = 1; rd_ovr_en = 1'b1; rd_ovr = 32'hDEAD_BEEF;
    exp_q.push_back('{busy: 2, maddr: 30'h41, be: 4'b0000, wd: 32'd0, ld: 1'b1, st: 1'b0, rdata: 32'hDEAD_BEEF});
    run_access(4'b1010, 32'h0000_0104, 32'd0, o_busy, o_maddr, o_be, o_wd, o_ld, o_st, o_stable, o_off, o_hold, o_rdata);
    go_idle();
    e = exp_q.pop_front();
    n_chk++; if (o_busy !== e.busy) begin n_fail++; $display("FAIL lw_busy_cycles: got %0d want %0d", o_busy, e.busy); end
    n_chk++; if (o_maddr !== e.maddr) begin n_fail++; $display("FAIL lw_mem_address: got %h want %h", o_maddr, e.maddr); end
    n_chk++; if ({o_ld, o_st, o_be} !== {e.ld, e.st, e.be}) begin n_fail++; $display("FAIL lw_strobes: got rd=%b wr=%b be=%b want rd=1 wr=0 be=0000", o_ld, o_st, o_be); end
    n_chk++; if (o_rdata !== e.rdata) begin n_fail++; $display("FAIL lw_read_data: got %h want %h", o_rdata, e.rdata); end
    n_chk++; if (o_off !== 1'b1) begin n_fail++; $display("FAIL lw_strobe_drop_done: got %b want 1", o_off); end
  endtask

  task automatic test_lb_lbu();
    wait_k = 3; rd_ovr_en = 1'b1; rd_ovr = 32'h80FF_0000;
    exp_q.push_back('{busy: 4, maddr: 30'h41, be: 4'b0000, wd: 32'd0, ld: 1'b1, st: 1'b0, rdata: 32'hFFFF_FF80});
    exp_q.push_back('{busy: 4, maddr: 30'h41, be: 4'b0000, wd: 32'd0, ld: 1'b1, st: 1'b0, rdata: 32'h0000_0080});
    for (int i = 0; i < 2; i++) begin
      run_access((i == 0) ? 4'b1000 : 4'b1100, 32'h0000_0107, 32'd0,
                 o_busy, o_maddr, o_be, o_wd, o_ld, o_st, o_stable, o_off, o_hold, o_rdata);
      go_idle();
      e = exp_q.pop_front();
      n_chk++; if (o_busy !== e.busy) begin n_fail++; $display("FAIL lb%0d_busy_cycles: got %0d want %0d", i, o_busy, e.busy); end
      n_chk++; if (o_rdata !== e.rdata) begin n_fail++; $display("FAIL lb%0d_read_data: got %h want %h", i, o_rdata, e.rdata); end
      n_chk++; if (o_stable !== 1'b1) begin n_fail++; $display("FAIL lb%0d_mem_stable: got %b want 1", i, o_stable); end
    end
  endtask

  task automatic test_sh();
    wait_k = 2; rd_ovr_en = 1'b0;
    exp_q.push_back('{busy: 3, maddr: 30'h4, be: 4'b1100, wd: 32'hABCD_ABCD, ld: 1'b0, st: 1'b1, rdata: 32'h0000_0080});
    run_access(4'b0010, 32'h0000_0012, 32'h1234_ABCD, o_busy, o_maddr, o_be, o_wd, o_ld, o_st, o_stable, o_off, o_hold, o_rdata);
    go_idle();
    e = exp_q.pop_front();
    n_chk++; if ({o_ld, o_st} !== {e.ld, e.st}) begin n_fail++; $display("FAIL sh_strobes: got rd=%b wr=%b want rd=0 wr=1", o_ld, o_st); end
    n_chk++; if (o_be !== e.be) begin n_fail++; $display("FAIL sh_byte_en: got %b want %b", o_be, e.be); end
    n_chk++; if (o_wd !== e.wd) begin n_fail++; $display("FAIL sh_writedata: got %h want %h", o_wd, e.wd); end
    n_chk++; if (o_maddr !== e.maddr) begin n_fail++; $display("FAIL sh_mem_address: got %h want %h", o_maddr, e.maddr); end
    n_chk++; if (o_rdata !== e.rdata) begin n_fail++; $display("FAIL sh_read_data_held: got %h want %h", o_rdata, e.rdata); end
    n_chk++; if (o_busy !== e.busy) begin n_fail++; $display("FAIL sh_busy_cycles: got %0d want %0d", o_busy, e.busy); end
  endtask

  task automatic test_misaligned();
    logic [3:0]  codes [0:3];
    logic [31:0] addrs [0:3];
    logic        saw_rd;
    codes = '{4'b1010, 4'b0011, 4'b1101, 4'b0010};
    addrs = '{32'h0000_0102, 32'h0000_0101, 32'h0000_0103, 32'h0000_0015};
    wait_k = 1; rd_ovr_en = 1'b1; rd_ovr = 32'h00AB_0000;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK); READ_WRITE = codes[i]; ADDRESS = addrs[i]; #1;
      n_chk++; if ({MISALIGNED, BUSYWAIT} !== 2'b10) begin n_fail++; $display("FAIL misal%0d_flags: got mis=%b busy=%b want mis=1 busy=0", i, MISALIGNED, BUSYWAIT); end
    end
    @(negedge CLK); READ_WRITE = 4'b1010; ADDRESS = 32'h0000_0102;
    saw_rd = 1'b0;
    repeat (3) begin
      @(negedge CLK); #1;
      if (MEM_READ || MEM_WRITE || BUSYWAIT) saw_rd = 1'b1;
    end
    n_chk++; if (saw_rd !== 1'b0) begin n_fail++; $display("FAIL misal_no_access: got 1 want 0"); end
    @(negedge CLK); READ_WRITE = 4'b0111; #1;
    n_chk++; if ({MISALIGNED, BUSYWAIT} !== 2'b00) begin n_fail++; $display("FAIL undef_code_flags: got mis=%b busy=%b want 00", MISALIGNED, BUSYWAIT); end
    exp_q.push_back('{busy: 2, maddr: 30'h40, be: 4'b0000, wd: 32'd0, ld: 1'b1, st: 1'b0, rdata: 32'hFFFF_FFAB});
    run_access(4'b1000, 32'h0000_0102, 32'd0, o_busy, o_maddr, o_be, o_wd, o_ld, o_st, o_stable, o_off, o_hold, o_rdata);
    go_idle();
    e = exp_q.pop_front();
    n_chk++; if (o_busy !== e.busy) begin n_fail++; $display("FAIL misal_then_lb_busy: got %0d want %0d", o_busy, e.busy); end
    n_chk++; if (o_rdata !== e.rdata) begin n_fail++; $display("FAIL misal_then_lb_data: got %h want %h", o_rdata, e.rdata); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  codes [0:3];
    logic [31:0] addrs [0:3];
    logic [31:0] wds   [0:3];
    codes = '{4'b0011, 4'b1010, 4'b0001, 4'b1001};
    addrs = '{32'h0000_0020, 32'h0000_0020, 32'h0000_0023, 32'h0000_0022};
    wds   = '{32'h1122_3344, 32'd0, 32'h0000_00F0, 32'd0};
    wait_k = 2; rd_ovr_en = 1'b0;
    exp_q.push_back('{busy: 3, maddr: 30'h8, be: 4'b1111, wd: 32'h1122_3344, ld: 1'b0, st: 1'b1, rdata: 32'hFFFF_FFAB});
    exp_q.push_back('{busy: 3, maddr: 30'h8, be: 4'b0000, wd: 32'd0, ld: 1'b1, st: 1'b0, rdata: 32'h1122_3344});
    exp_q.push_back('{busy: 3, maddr: 30'h8, be: 4'b1000, wd: 32'hF0F0_F0F0, ld: 1'b0, st: 1'b1, rdata: 32'h1122_3344});
    exp_q.push_back('{busy: 3, maddr: 30'h8, be: 4'b0000, wd: 32'd0, ld: 1'b1, st: 1'b0, rdata: 32'hFFFF_F022});
    for (int i = 0; i < 4; i++) begin
      run_access(codes[i], addrs[i], wds[i], o_busy, o_maddr, o_be, o_wd, o_ld, o_st, o_stable, o_off, o_hold, o_rdata);
      e = exp_q.pop_front();
      n_chk++; if (o_busy !== e.busy) begin n_fail++; $display("FAIL b2b%0d_busy_cycles: got %0d want %0d", i, o_busy, e.busy); end
      n_chk++; if (o_hold !== 1'b1) begin n_fail++; $display("FAIL b2b%0d_pipe_hold: got %b want 1", i, o_hold); end
      n_chk++; if ({o_ld, o_st, o_be} !== {e.ld, e.st, e.be}) begin n_fail++; $display("FAIL b2b%0d_strobes: got %b%b %b want %b%b %b", i, o_ld, o_st, o_be, e.ld, e.st, e.be); end
      n_chk++; if (e.st && o_wd !== e.wd) begin n_fail++; $display("FAIL b2b%0d_writedata: got %h want %h", i, o_wd, e.wd); end
      n_chk++; if (o_rdata !== e.rdata) begin n_fail++; $display("FAIL b2b%0d_read_data: got %h want %h", i, o_rdata, e.rdata); end
    end
    go_idle();
  endtask

  task automatic test_reset_access();
    int busy;
    wait_k = 6; rd_ovr_en = 1'b1; rd_ovr = 32'hDEAD_BEEF;
    @(negedge CLK); READ_WRITE = 4'b1010; ADDRESS = 32'h0000_0104;
    repeat (2) @(negedge CLK);
    #1;
    n_chk++; if (MEM_READ !== 1'b1) begin n_fail++; $display("FAIL rsta_read_active: got %b want 1", MEM_READ); end
    RESET = 1'b0; #1;
    n_chk++; if (MEM_READ !== 1'b0) begin n_fail++; $display("FAIL rsta_read_drop: got %b want 0", MEM_READ); end
    n_chk++; if (READ_DATA !== 32'd0) begin n_fail++; $display("FAIL rsta_read_data: got %h want 0", READ_DATA); end
    n_chk++; if (BUSYWAIT !== 1'b0) begin n_fail++; $display("FAIL rsta_busywait: got %b want 0", BUSYWAIT); end
    @(negedge CLK); wait_k = 1; RESET = 1'b1; #1;
    busy = 0;
    for (int c = 0; c < 40; c++) begin
      if (!BUSYWAIT) break;
      busy++;
      @(negedge CLK); #1;
    end
    n_chk++; if (busy !== 2) begin n_fail++; $display("FAIL rsta_restart_busy: got %0d want 2", busy); end
    n_chk++; if (READ_DATA !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rsta_restart_data: got %h want deadbeef", READ_DATA); end
    go_idle();
  endtask

  initial begin
    test_reset_init();
    test_lw();
    test_lb_lbu();
    test_sh();
    test_misaligned();
    test_back_to_back();
    test_reset_access();
    repeat (2) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
